wb_bus_mon_v2: RTL and testbench
================================

Name: wb_bus_mon_v2

Overview:
Synthesizable, parametrised WISHBONE B3 protocol monitor. It observes one master/slave link and checks handshake, hold, termination, timeout and incrementing-burst rules. Results are reported in hardware rather than by simulation printouts: sticky violation flags, saturating counters, first-error capture and an interrupt. It sits beside any WISHBONE master port in the Ethernet subsystem and is readable by a host or testbench.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
SEL_W, DATA_W/8, byte-select width (derived, not overridable)
CNT_W, 16, width of violation and transaction counters
TIMEOUT, 256, stall cycles before timeout (0 disables the check)
IRQ_MASK, 8'hFF, violation classes that drive IRQ_O

Ports:
CLK_I  in  1  clock, all logic on rising edge
RST_I  in  1  synchronous active-low reset
CYC_O  in  1  master cycle
STB_O  in  1  master strobe
WE_O  in  1  master write enable
ADDR_O  in  ADDR_W  master byte address
SEL_O  in  SEL_W  byte selects
DAT_O  in  DATA_W  master write data
CTI_O  in  3  cycle type identifier
DAT_I  in  DATA_W  slave read data (monitored for hold only)
ACK_I  in  1  slave acknowledge
ERR_I  in  1  slave error
RTY_I  in  1  slave retry
CHECK_CTI_I  in  1  enables classes 5-7
CLR_I  in  1  synchronous clear of flags, counters and capture
ERR_FLAGS_O  out  8  sticky per-class violation flags
ERR_CNT_O  out  CNT_W  total violations, saturating
TXN_CNT_O  out  CNT_W  terminated transfers (ACK/ERR/RTY with STB), saturating
FIRST_CODE_O  out  3  class of first violation since clear
FIRST_ADR_O  out  ADDR_W  ADDR_O sampled at first violation
FIRST_VLD_O  out  1  first-error capture valid
IRQ_O  out  1  registered OR of (ERR_FLAGS_O & IRQ_MASK)

Behaviour:
- Reset (RST_I=0 at edge): all outputs and internal state go to 0; no checks are performed. On the first edge after release, previous-cycle state counts as idle (CYC=STB=term=0).
- Every check samples the current and previous-edge values. A violation detected at edge N is visible on the outputs after edge N. IRQ_O follows one cycle later.
- term = ACK_I|ERR_I|RTY_I. Violation classes (bit index = code):
  - 0 NO_CYC: STB/ACK/ERR/RTY high while CYC_O=0.
  - 1 MULTI_TERM: two or more of ACK/ERR/RTY high at the same edge.
  - 2 MASTER_HOLD: previous STB=1 and previous term=0, and any of CYC, STB, WE, ADDR, SEL, or DAT_O (if WE=1) changed.
  - 3 TERM_NO_STB: term=1 while CYC=1, STB=0.
  - 4 TIMEOUT: stall counter reaches TIMEOUT.
  - 5 BURST_ADR: in a burst (previous acked CTI=010, CTI_O still 010 or 111), the next acked ADDR_O differs from previous ADDR_O+SEL_W. Addition is modulo 2^ADDR_W.
  - 6 CTI_EOB: CYC falls after an acked 010 transfer with no 111 transfer, and the last termination was not ERR/RTY.
  - 7 CTI_CLASSIC: CTI_O was 000 at the first acked transfer and changes value later in the same cycle.
- Stall counter (width clog2(TIMEOUT+1)):
  - Increments while CYC&STB&~term; clears on term, STB=0 or CYC=0.
  - Saturates at TIMEOUT; flags class 4 exactly once per stall.
- Several classes at one edge: all flags are set and ERR_CNT_O adds the number of classes (popcount). FIRST_CODE_O takes the lowest class index.
- Counters hold at 2^CNT_W-1; they never wrap.
- First-error capture loads only when FIRST_VLD_O=0, then holds until CLR_I or reset.
- CLR_I=1 with a violation at the same edge: clear applies first, then the new violation is recorded (flag set, ERR_CNT_O=popcount, capture loaded).
- CHECK_CTI_I=0: classes 5-7 are never flagged and burst trackers are held idle.
- Reset asserted mid-cycle: all tracking is abandoned. A cycle still active after release starts checking fresh, so no hold violation is flagged on the first edge.

Decomposition:
- Shared defines file wb_mon_defines.v: violation code constants (VIO_NO_CYC..VIO_CTI_CLASSIC) and CTI encodings (CTI_CLASSIC=000, CTI_INCR=010, CTI_EOB=111).
- One sub-module, wb_mon_sat_cnt (parametrised width, increment amount, clear, saturation), instanced for ERR_CNT_O, TXN_CNT_O and the stall counter.

Test Plan:
- Reset, 4 clean single reads with ACK after 2 waits -> ERR_FLAGS_O=0, TXN_CNT_O=4, IRQ_O=0.
- ADDR_O changes 0x100->0x104 during an un-acked STB -> ERR_FLAGS_O=8'h04, FIRST_CODE_O=2, FIRST_ADR_O=0x104, ERR_CNT_O=1, IRQ_O=1 one cycle later.
- CTI=010 burst at 0x0,0x4,0xC,0x10(111) with ACKs -> bit5 set, FIRST_ADR_O=0xC. Same burst without the 111 beat, CYC drops -> bit6 set.
- TIMEOUT=8, STB held 20 cycles without term -> bit4 set at the 8th stall edge, ERR_CNT_O=1 (not 13).
- ACK_I and RTY_I together with CLR_I=1 at the same edge -> ERR_FLAGS_O=8'h02, ERR_CNT_O=1, FIRST_VLD_O=1.
- CNT_W=4, force 20 NO_CYC violations, then RST_I=0 mid-burst -> ERR_CNT_O saturates at 15; after reset all outputs 0 and no class-2 flag on resumed cycle.

Source files
------------

// File: rtl/wb_bus_mon_v2_pkg.sv
// ============================================================================
// Module  : wb_bus_mon_v2_pkg
// Brief   : Shared violation codes, CTI encodings and helpers for the
//           WISHBONE B3 bus monitor.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package wb_bus_mon_v2_pkg;

    localparam logic [2:0] c_vio_no_cyc      = 3'd0;
    localparam logic [2:0] c_vio_multi_term  = 3'd1;
    localparam logic [2:0] c_vio_master_hold = 3'd2;
    localparam logic [2:0] c_vio_term_no_stb = 3'd3;
    localparam logic [2:0] c_vio_timeout     = 3'd4;
    localparam logic [2:0] c_vio_burst_adr   = 3'd5;
    localparam logic [2:0] c_vio_cti_eob     = 3'd6;
    localparam logic [2:0] c_vio_cti_classic = 3'd7;

    localparam logic [2:0] c_cti_classic = 3'b000;
    localparam logic [2:0] c_cti_incr    = 3'b010;
    localparam logic [2:0] c_cti_eob     = 3'b111;

    function automatic logic [3:0] f_popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Lowest set index wins when several classes fire together.
    function automatic logic [2:0] f_lowest8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_bus_mon_v2_sat_cnt.sv
// ============================================================================
// Module  : wb_mon_sat_cnt
// Brief   : Saturating up-counter with synchronous clear; a clear and an
//           increment at the same edge yield the increment from zero.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module wb_mon_sat_cnt #(
    parameter int               WIDTH = 16,
    parameter int               INC_W = 1,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             i_clr,
    input  logic [INC_W-1:0] i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    localparam int c_sum_w = ((WIDTH > INC_W) ? WIDTH : INC_W) + 1;

    logic [WIDTH-1:0]   r_cnt;
    logic [WIDTH-1:0]   w_base;
    logic [WIDTH-1:0]   w_next;
    logic [c_sum_w-1:0] w_sum;

    always_comb begin
        w_base = i_clr ? '0 : r_cnt;
        w_sum  = c_sum_w'(w_base) + c_sum_w'(i_inc);
        w_next = (w_sum > c_sum_w'(MAX)) ? MAX : w_sum[WIDTH-1:0];
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/wb_bus_mon_v2.sv
// ============================================================================
// Module  : wb_bus_mon_v2
// Brief   : WISHBONE B3 protocol monitor with sticky flags, saturating
//           counters, first-error capture and a maskable interrupt.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module wb_bus_mon_v2 #(
    parameter int         ADDR_W   = 32,
    parameter int         DATA_W   = 32,
    parameter int         CNT_W    = 16,
    parameter int         TIMEOUT  = 256,
    parameter logic [7:0] IRQ_MASK = 8'hFF,
    localparam int        SEL_W    = DATA_W / 8
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              CYC_O,
    input  logic              STB_O,
    input  logic              WE_O,
    input  logic [ADDR_W-1:0] ADDR_O,
    input  logic [SEL_W-1:0]  SEL_O,
    input  logic [DATA_W-1:0] DAT_O,
    input  logic [2:0]        CTI_O,
    input  logic [DATA_W-1:0] DAT_I,
    input  logic              ACK_I,
    input  logic              ERR_I,
    input  logic              RTY_I,
    input  logic              CHECK_CTI_I,
    input  logic              CLR_I,
    output logic [7:0]        ERR_FLAGS_O,
    output logic [CNT_W-1:0]  ERR_CNT_O,
    output logic [CNT_W-1:0]  TXN_CNT_O,
    output logic [2:0]        FIRST_CODE_O,
    output logic [ADDR_W-1:0] FIRST_ADR_O,
    output logic              FIRST_VLD_O,
    output logic              IRQ_O
);

    import wb_bus_mon_v2_pkg::*;

    localparam int c_stall_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic              w_term;
    logic              w_stall;
    logic              w_ack_xfer;
    logic              w_hold_chg;
    logic              w_timeout;
    logic [7:0]        w_vio;
    logic              w_unused_ok;

    logic              r_prev_cyc;
    logic              r_prev_stb;
    logic              r_prev_we;
    logic              r_prev_term;
    logic [ADDR_W-1:0] r_prev_adr;
    logic [SEL_W-1:0]  r_prev_sel;
    logic [DATA_W-1:0] r_prev_dat;

    logic              r_burst_vld;
    logic [ADDR_W-1:0] r_burst_adr;
    logic              r_eob_pend;
    logic              r_last_abort;
    logic              r_first_done;
    logic              r_classic;

    logic [7:0]        r_flags;
    logic              r_first_vld;
    logic [2:0]        r_first_code;
    logic [ADDR_W-1:0] r_first_adr;
    logic              r_irq;

    assign w_term      = ACK_I | ERR_I | RTY_I;
    assign w_stall     = CYC_O & STB_O & ~w_term;
    assign w_ack_xfer  = CYC_O & STB_O & ACK_I;
    assign w_unused_ok = ^{DAT_I, w_stall};

    assign w_hold_chg = (CYC_O != r_prev_cyc) | (STB_O != r_prev_stb) |
                        (WE_O != r_prev_we) | (ADDR_O != r_prev_adr) |
                        (SEL_O != r_prev_sel) | (WE_O & (DAT_O != r_prev_dat));

    always_comb begin
        w_vio = '0;
        w_vio[c_vio_no_cyc]      = ~CYC_O & (STB_O | w_term);
        w_vio[c_vio_multi_term]  = (ACK_I & ERR_I) | (ACK_I & RTY_I) | (ERR_I & RTY_I);
        w_vio[c_vio_master_hold] = r_prev_stb & ~r_prev_term & w_hold_chg;
        w_vio[c_vio_term_no_stb] = w_term & CYC_O & ~STB_O;
        w_vio[c_vio_timeout]     = w_timeout;
        w_vio[c_vio_burst_adr]   = CHECK_CTI_I & w_ack_xfer & r_burst_vld &
                                   ((CTI_O == c_cti_incr) | (CTI_O == c_cti_eob)) &
                                   (ADDR_O != r_burst_adr + ADDR_W'(SEL_W));
        w_vio[c_vio_cti_eob]     = CHECK_CTI_I & r_prev_cyc & ~CYC_O &
                                   r_eob_pend & ~r_last_abort;
        w_vio[c_vio_cti_classic] = CHECK_CTI_I & CYC_O & STB_O & r_classic &
                                   (CTI_O != c_cti_classic);
    end

    // Stall counter saturates at TIMEOUT so the timeout fires once per stall.
    generate
        if (TIMEOUT > 0) begin : g_timeout
            logic [c_stall_w-1:0] w_stall_cnt;

            wb_mon_sat_cnt #(
                .WIDTH (c_stall_w),
                .INC_W (1),
                .MAX   (c_stall_w'(TIMEOUT))
            ) u_stall_cnt (
                .CLK_I (CLK_I),
                .RST_I (RST_I),
                .i_clr (~w_stall),
                .i_inc (w_stall),
                .o_cnt (w_stall_cnt)
            );

            assign w_timeout = w_stall & (w_stall_cnt == c_stall_w'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            r_prev_cyc  <= 1'b0;
            r_prev_stb  <= 1'b0;
            r_prev_we   <= 1'b0;
            r_prev_term <= 1'b0;
            r_prev_adr  <= '0;
            r_prev_sel  <= '0;
            r_prev_dat  <= '0;
        end else begin
            r_prev_cyc  <= CYC_O;
            r_prev_stb  <= STB_O;
            r_prev_we   <= WE_O;
            r_prev_term <= w_term;
            r_prev_adr  <= ADDR_O;
            r_prev_sel  <= SEL_O;
            r_prev_dat  <= DAT_O;
        end
    end

    // Burst/CTI trackers live only within one CYC and only when enabled.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            r_burst_vld  <= 1'b0;
            r_burst_adr  <= '0;
            r_eob_pend   <= 1'b0;
            r_last_abort <= 1'b0;
            r_first_done <= 1'b0;
            r_classic    <= 1'b0;
        end else if (!CHECK_CTI_I || !CYC_O) begin
            r_burst_vld  <= 1'b0;
            r_eob_pend   <= 1'b0;
            r_last_abort <= 1'b0;
            r_first_done <= 1'b0;
            r_classic    <= 1'b0;
        end else begin
            if (w_ack_xfer) begin
                r_burst_vld <= (CTI_O == c_cti_incr);
                r_burst_adr <= ADDR_O;
                if (CTI_O == c_cti_incr) begin
                    r_eob_pend <= 1'b1;
                end else if (CTI_O == c_cti_eob) begin
                    r_eob_pend <= 1'b0;
                end
            end
            if (STB_O && w_term) begin
                r_last_abort <= ERR_I | RTY_I;
            end
            if (w_vio[c_vio_cti_classic]) begin
                r_classic <= 1'b0;
            end else if (w_ack_xfer && !r_first_done) begin
                r_first_done <= 1'b1;
                r_classic    <= (CTI_O == c_cti_classic);
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            r_flags      <= '0;
            r_first_vld  <= 1'b0;
            r_first_code <= '0;
            r_first_adr  <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_flags <= (CLR_I ? 8'h00 : r_flags) | w_vio;
            if ((|w_vio) && (CLR_I || !r_first_vld)) begin
                r_first_vld  <= 1'b1;
                r_first_code <= f_lowest8(w_vio);
                r_first_adr  <= ADDR_O;
            end else if (CLR_I) begin
                r_first_vld  <= 1'b0;
                r_first_code <= '0;
                r_first_adr  <= '0;
            end
            r_irq <= |(r_flags & IRQ_MASK);
        end
    end

    wb_mon_sat_cnt #(
        .WIDTH (CNT_W),
        .INC_W (4)
    ) u_err_cnt (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .i_clr (CLR_I),
        .i_inc (f_popcount8(w_vio)),
        .o_cnt (ERR_CNT_O)
    );

    wb_mon_sat_cnt #(
        .WIDTH (CNT_W),
        .INC_W (1)
    ) u_txn_cnt (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .i_clr (CLR_I),
        .i_inc (STB_O & w_term),
        .o_cnt (TXN_CNT_O)
    );

    assign ERR_FLAGS_O  = r_flags;
    assign FIRST_CODE_O = r_first_code;
    assign FIRST_ADR_O  = r_first_adr;
    assign FIRST_VLD_O  = r_first_vld;
    assign IRQ_O        = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_wb_bus_mon_v2.sv
// ============================================================================
// Module  : tb_wb_bus_mon_v2
// Brief   : Directed and randomized self-checking bench for wb_bus_mon_v2.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_bus_mon_v2;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int SEL_W   = DATA_W / 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              CLK_I = 1'b0;
    logic              RST_I;
    logic              CYC_O, STB_O, WE_O;
    logic [ADDR_W-1:0] ADDR_O;
    logic [SEL_W-1:0]  SEL_O;
    logic [DATA_W-1:0] DAT_O;
    logic [2:0]        CTI_O;
    logic [DATA_W-1:0] DAT_I;
    logic              ACK_I, ERR_I, RTY_I;
    logic              CHECK_CTI_I, CLR_I;
    logic [7:0]        ERR_FLAGS_O;
    logic [CNT_W-1:0]  ERR_CNT_O;
    logic [CNT_W-1:0]  TXN_CNT_O;
    logic [2:0]        FIRST_CODE_O;
    logic [ADDR_W-1:0] FIRST_ADR_O;
    logic              FIRST_VLD_O;
    logic              IRQ_O;

    int checks = 0;
    int errors = 0;

    wb_bus_mon_v2 #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .IRQ_MASK (8'hFF)
    ) dut (
        .CLK_I        (CLK_I),
        .RST_I        (RST_I),
        .CYC_O        (CYC_O),
        .STB_O        (STB_O),
        .WE_O         (WE_O),
        .ADDR_O       (ADDR_O),
        .SEL_O        (SEL_O),
        .DAT_O        (DAT_O),
        .CTI_O        (CTI_O),
        .DAT_I        (DAT_I),
        .ACK_I        (ACK_I),
        .ERR_I        (ERR_I),
        .RTY_I        (RTY_I),
        .CHECK_CTI_I  (CHECK_CTI_I),
        .CLR_I        (CLR_I),
        .ERR_FLAGS_O  (ERR_FLAGS_O),
        .ERR_CNT_O    (ERR_CNT_O),
        .TXN_CNT_O    (TXN_CNT_O),
        .FIRST_CODE_O (FIRST_CODE_O),
        .FIRST_ADR_O  (FIRST_ADR_O),
        .FIRST_VLD_O  (FIRST_VLD_O),
        .IRQ_O        (IRQ_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        CYC_O = 1'b0; STB_O = 1'b0;
        ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
    endtask

    task automatic clr_pulse();
        bus_idle();
        CLR_I = 1'b1;
        tick();
        CLR_I = 1'b0;
    endtask

    // Classic single transfer: waits stall edges, one ACK edge, one idle edge.
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input int waits);
        CYC_O = 1'b1; STB_O = 1'b1; WE_O = we; ADDR_O = adr; DAT_O = dat;
        SEL_O = '1; CTI_O = 3'b000; ACK_I = 1'b0;
        repeat (waits) tick();
        ACK_I = 1'b1;
        tick();
        bus_idle();
        tick();
    endtask

    // Zero-wait burst beat with ACK at the same edge.
    task automatic beat(input logic [31:0] adr, input logic [2:0] cti);
        CYC_O = 1'b1; STB_O = 1'b1; WE_O = 1'b0; ADDR_O = adr; CTI_O = cti;
        SEL_O = '1; ACK_I = 1'b1;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, 64'(ERR_FLAGS_O), 64'h0);
        chk({tag, "_errcnt"}, 64'(ERR_CNT_O), 64'h0);
        chk({tag, "_txncnt"}, 64'(TXN_CNT_O), 64'h0);
        chk({tag, "_code"}, 64'(FIRST_CODE_O), 64'h0);
        chk({tag, "_adr"}, 64'(FIRST_ADR_O), 64'h0);
        chk({tag, "_vld"}, 64'(FIRST_VLD_O), 64'h0);
        chk({tag, "_irq"}, 64'(IRQ_O), 64'h0);
    endtask

    initial begin
        int          m_txn;
        int          m_err;
        bit          m_first;
        logic [31:0] m_first_adr;
        logic [31:0] r_adr;

        RST_I = 1'b0; CLR_I = 1'b0; CHECK_CTI_I = 1'b1;
        WE_O = 1'b0; ADDR_O = '0; SEL_O = '0; DAT_O = '0; CTI_O = 3'b000;
        DAT_I = '0;
        bus_idle();
        repeat (3) tick();
        chk_all_zero("reset");
        RST_I = 1'b1;

        // Clean single reads with two wait states each.
        for (int i = 0; i < 4; i++) xfer(32'h10 + 32'(4 * i), 1'b0, 32'h0, 2);
        chk("clean_flags", 64'(ERR_FLAGS_O), 64'h0);
        chk("clean_txn", 64'(TXN_CNT_O), 64'd4);
        chk("clean_irq", 64'(IRQ_O), 64'h0);
        chk("clean_err", 64'(ERR_CNT_O), 64'h0);

        // Address moves while the strobe is still waiting.
        CYC_O = 1'b1; STB_O = 1'b1; WE_O = 1'b0; ADDR_O = 32'h100; CTI_O = 3'b000;
        tick();
        ADDR_O = 32'h104;
        tick();
        chk("hold_flags", 64'(ERR_FLAGS_O), 64'h04);
        chk("hold_code", 64'(FIRST_CODE_O), 64'd2);
        chk("hold_adr", 64'(FIRST_ADR_O), 64'h104);
        chk("hold_err", 64'(ERR_CNT_O), 64'd1);
        chk("hold_irq_early", 64'(IRQ_O), 64'h0);
        ACK_I = 1'b1;
        tick();
        chk("hold_irq_late", 64'(IRQ_O), 64'h1);
        bus_idle();
        tick();

        // Double termination on the same edge as a clear.
        CYC_O = 1'b1; STB_O = 1'b1; ADDR_O = 32'h200;
        tick();
        ACK_I = 1'b1; RTY_I = 1'b1; CLR_I = 1'b1;
        tick();
        CLR_I = 1'b0;
        chk("multi_flags", 64'(ERR_FLAGS_O), 64'h02);
        chk("multi_err", 64'(ERR_CNT_O), 64'd1);
        chk("multi_vld", 64'(FIRST_VLD_O), 64'h1);
        chk("multi_code", 64'(FIRST_CODE_O), 64'd1);
        chk("multi_txn", 64'(TXN_CNT_O), 64'd1);
        bus_idle();
        tick();

        // Termination without strobe inside a cycle.
        clr_pulse();
        CYC_O = 1'b1; STB_O = 1'b0; ACK_I = 1'b1;
        tick();
        bus_idle();
        tick();
        chk("tns_flags", 64'(ERR_FLAGS_O), 64'h08);
        chk("tns_txn", 64'(TXN_CNT_O), 64'd0);

        // Stall long enough for one timeout.
        clr_pulse();
        CYC_O = 1'b1; STB_O = 1'b1; ADDR_O = 32'h300;
        repeat (TIMEOUT - 1) tick();
        chk("to_before", 64'(ERR_FLAGS_O), 64'h00);
        tick();
        chk("to_flags", 64'(ERR_FLAGS_O), 64'h10);
        chk("to_code", 64'(FIRST_CODE_O), 64'd4);
        repeat (20 - TIMEOUT) tick();
        chk("to_err_once", 64'(ERR_CNT_O), 64'd1);
        ACK_I = 1'b1;
        tick();
        bus_idle();
        tick();

        // Incrementing burst with a skipped address.
        clr_pulse();
        beat(32'h0, 3'b010); beat(32'h4, 3'b010); beat(32'hC, 3'b010);
        chk("badr_flags", 64'(ERR_FLAGS_O), 64'h20);
        chk("badr_adr", 64'(FIRST_ADR_O), 64'hC);
        beat(32'h10, 3'b111);
        bus_idle();
        tick();
        chk("badr_final", 64'(ERR_FLAGS_O), 64'h20);
        chk("badr_err", 64'(ERR_CNT_O), 64'd1);

        // Burst that ends without an end-of-burst beat.
        clr_pulse();
        for (int i = 0; i < 4; i++) beat(32'(4 * i), 3'b010);
        bus_idle();
        tick();
        chk("eob_flags", 64'(ERR_FLAGS_O), 64'h40);
        chk("eob_code", 64'(FIRST_CODE_O), 64'd6);
        chk("eob_adr", 64'(FIRST_ADR_O), 64'hC);

        // Classic cycle whose CTI changes after the first ack.
        clr_pulse();
        beat(32'h20, 3'b000);
        beat(32'h24, 3'b010);
        chk("cls_flags", 64'(ERR_FLAGS_O), 64'h80);
        chk("cls_code", 64'(FIRST_CODE_O), 64'd7);
        bus_idle();
        tick();
        chk("cls_final", 64'(ERR_FLAGS_O), 64'hC0);
        chk("cls_err", 64'(ERR_CNT_O), 64'd2);

        // CTI checks disabled: bad burst with no EOB must be silent.
        clr_pulse();
        CHECK_CTI_I = 1'b0;
        beat(32'h0, 3'b010); beat(32'h4, 3'b010); beat(32'hC, 3'b010);
        bus_idle();
        tick();
        chk("nocti_flags", 64'(ERR_FLAGS_O), 64'h0);
        chk("nocti_txn", 64'(TXN_CNT_O), 64'd3);
        CHECK_CTI_I = 1'b1;

        // Random mix of clean transfers and stray terminations outside CYC.
        clr_pulse();
        m_txn = 0; m_err = 0; m_first = 1'b0; m_first_adr = '0;
        for (int i = 0; i < 24; i++) begin
            r_adr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) begin
                ADDR_O = r_adr;
                case ($urandom_range(0, 2))
                    0:       ACK_I = 1'b1;
                    1:       ERR_I = 1'b1;
                    default: RTY_I = 1'b1;
                endcase
                tick();
                bus_idle();
                tick();
                m_err = (m_err + 1 > CNT_MAX) ? CNT_MAX : m_err + 1;
                if (!m_first) begin
                    m_first     = 1'b1;
                    m_first_adr = r_adr;
                end
            end else begin
                xfer(r_adr, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 6)));
                m_txn = (m_txn + 1 > CNT_MAX) ? CNT_MAX : m_txn + 1;
            end
            chk("rnd_txn", 64'(TXN_CNT_O), 64'(m_txn));
            chk("rnd_err", 64'(ERR_CNT_O), 64'(m_err));
            chk("rnd_flags", 64'(ERR_FLAGS_O), (m_err > 0) ? 64'h01 : 64'h00);
        end
        chk("rnd_vld", 64'(FIRST_VLD_O), 64'(m_first));
        if (m_first) begin
            chk("rnd_first_adr", 64'(FIRST_ADR_O), 64'(m_first_adr));
            chk("rnd_first_code", 64'(FIRST_CODE_O), 64'd0);
        end

        // Saturate the error counter, then reset in the middle of a burst.
        clr_pulse();
        CYC_O = 1'b0; STB_O = 1'b1; ADDR_O = 32'h400; WE_O = 1'b0;
        repeat (20) tick();
        chk("sat_err", 64'(ERR_CNT_O), 64'(CNT_MAX));
        chk("sat_flags", 64'(ERR_FLAGS_O), 64'h01);
        CYC_O = 1'b1; CTI_O = 3'b010; ADDR_O = 32'h0; ACK_I = 1'b1;
        tick();
        chk("sat_hold_err", 64'(ERR_CNT_O), 64'(CNT_MAX));
        chk("sat_hold_flags", 64'(ERR_FLAGS_O), 64'h05);
        ADDR_O = 32'h4; ACK_I = 1'b0;
        tick();
        RST_I = 1'b0; ADDR_O = 32'h8;
        repeat (2) tick();
        chk_all_zero("midrst");
        RST_I = 1'b1;
        beat(32'h8, 3'b010);
        beat(32'hC, 3'b111);
        bus_idle();
        tick();
        chk("resume_flags", 64'(ERR_FLAGS_O), 64'h0);
        chk("resume_err", 64'(ERR_CNT_O), 64'h0);
        chk("resume_txn", 64'(TXN_CNT_O), 64'd2);
        chk("resume_irq", 64'(IRQ_O), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
